// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// op encoding and the default operand width.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider producing registered hi/lo.
// Optional MULDIV_EARLY_EXIT_EN: multiply ends once the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned SUM_W = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             op_q, op_d;
    logic             dz_q, dz_d;
    logic             wait_q, wait_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   add_x, add_y;
    logic             add_cin;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] step_acc;
    logic [ACC_W-1:0] mul_res;
    logic             mul_last;
    logic             last_step;

    // Shared adder: acc_hi + (a & multiplier lsb) for multiply, shifted remainder - b for divide
    always_comb begin
        if (op_q == OP_DIV) begin
            add_x   = acc_q[ACC_W-2:WIDTH-1];
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_q[ACC_W-1:WIDTH]};
            add_y   = {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
            add_cin = 1'b0;
        end
        sum = SUM_W'(add_x) + SUM_W'(add_y) + SUM_W'(add_cin);
    end

    // One iteration; sum[WIDTH+1] is the no-borrow flag of the divide trial subtraction
    always_comb begin
        if (op_q == OP_DIV) begin
            if (sum[WIDTH+1]) begin
                step_acc = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {acc_q[ACC_W-2:0], 1'b0};
            end
        end else begin
            step_acc = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
        end
    end

`ifdef MULDIV_EARLY_EXIT_EN
    // Unconsumed multiplier bits sit right-justified in the low word; the product
    // needs the skipped right shifts applied when the loop ends early.
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask = ({WIDTH{1'b1}} >> cnt_q) >> 1;
    assign mul_last = (cnt_q == LAST) || ((step_acc[WIDTH-1:0] & rem_mask) == '0);
    assign mul_res  = acc_q >> (LAST - cnt_q);
`else
    assign mul_last = (cnt_q == LAST);
    assign mul_res  = acc_q;
`endif

    assign last_step = (op_q == OP_MUL) ? mul_last : (cnt_q == LAST);

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        dz_d       = dz_q;
        wait_d     = wait_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    wait_d = 1'b0;
                    if (op == OP_MUL) begin
                        acc_d   = {{WIDTH{1'b0}}, b};
                        opnd_d  = a;
                        state_d = MUL;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, a};
                        opnd_d = b;
                        if (b == '0) begin
                            // Divide-by-zero spends one extra FIN cycle to keep a 2-cycle latency
                            dz_d    = 1'b1;
                            wait_d  = 1'b1;
                            state_d = FIN;
                        end else begin
                            state_d = DIV;
                        end
                    end
                end
            end
            MUL, DIV: begin
                acc_d = step_acc;
                if (last_step) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                if (wait_q) begin
                    wait_d = 1'b0;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (dz_q) begin
                        hi_d       = acc_q[WIDTH-1:0];
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else if (op_q == OP_MUL) begin
                        {hi_d, lo_d} = mul_res;
                        div_zero_d   = 1'b0;
                    end else begin
                        hi_d       = acc_q[ACC_W-1:WIDTH];
                        lo_d       = acc_q[WIDTH-1:0];
                        div_zero_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= 1'b0;
            dz_q       <= 1'b0;
            wait_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            dz_q       <= dz_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed and random mul/div, busy protocol, mid-op reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [2*W-1:0] p;
        if (o == OP_MUL) begin
            p     = (2*W)'(x) * (2*W)'(y);
            e.hi  = p[2*W-1:W];
            e.lo  = p[W-1:0];
            e.dz  = 1'b0;
            e.lat = W + 1;
`ifdef MULDIV_EARLY_EXIT_EN
            e.lat = 2;
            for (int i = 0; i < W; i++) if (y[i]) e.lat = 2 + i;
`endif
        end else if (y == '0) begin
            e.hi  = x;
            e.lo  = '1;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            e.hi  = x % y;
            e.lo  = x / y;
            e.dz  = 1'b0;
            e.lat = W + 1;
        end
        return e;
    endfunction

    // Drives a one-cycle start; returns just after the sampling edge
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit repulse);
        int           lat;
        bit           seen;
        bit           hold_ok;
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        exp_t         e;
        lat     = 0;
        seen    = 1'b0;
        hold_ok = 1'b1;
        h0      = hi;
        l0      = lo;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (repulse && lat == 5) begin
                start = 1'b1;
                op    = OP_MUL;
                a     = 16'd9;
                b     = 16'd9;
            end
            if (repulse && lat == 6) begin
                start = 1'b0;
                a     = 16'h7777;
            end
            if (done) seen = 1'b1;
            else if (hi !== h0 || lo !== l0 || busy !== 1'b1) hold_ok = 1'b0;
        end
        check({tag, "/done_seen"}, 32'(seen), 32'd1);
        check({tag, "/hold_busy"}, 32'(hold_ok), 32'd1);
        if (seen) begin
            check({tag, "/sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "/latency"}, 32'(lat), 32'(e.lat));
                check({tag, "/hi"}, 32'(hi), 32'(e.hi));
                check({tag, "/lo"}, 32'(lo), 32'(e.lo));
                check({tag, "/div_zero"}, 32'(div_zero), 32'(e.dz));
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1 if (done) n++;
        end
    endtask

    initial begin
        int n;
        logic rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0;
        start = 1'b1;
        op    = OP_MUL;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/hi", 32'(hi), 32'd0);
        check("rst/lo", 32'(lo), 32'd0);
        check("rst/div_zero", 32'(div_zero), 32'd0);

        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        count_done(40, n);
        check("idle/no_done", 32'(n), 32'd0);

        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("mul_full", 1'b0);
        issue(OP_DIV, 16'd100, 16'd7, 1'b1);
        wait_done("div_100_7", 1'b0);
        issue(OP_DIV, 16'd5, 16'd9, 1'b1);
        wait_done("div_5_9", 1'b0);
        issue(OP_DIV, 16'h1234, 16'h0000, 1'b1);
        wait_done("div_zero", 1'b0);
        issue(OP_MUL, 16'd3, 16'd4, 1'b1);
        wait_done("mul_3_4", 1'b0);
        issue(OP_DIV, 16'hFFFF, 16'h0001, 1'b1);
        wait_done("div_by_one", 1'b0);
        issue(OP_MUL, 16'hABCD, 16'h0000, 1'b1);
        wait_done("mul_by_zero", 1'b0);
        issue(OP_MUL, 16'h1234, 16'h0001, 1'b1);
        wait_done("mul_b1", 1'b0);
        issue(OP_MUL, 16'h1234, 16'h8000, 1'b1);
        wait_done("mul_b8000", 1'b0);

        for (int i = 0; i < 8; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = W'($urandom);
            rb  = W'($urandom);
            issue(rop, ra, rb, 1'b1);
            wait_done("rand", 1'b0);
        end

        // Restart ignored while busy; operand change mid-op has no effect
        issue(OP_MUL, 16'd3, 16'd4, 1'b1);
        wait_done("busy_repulse", 1'b1);
        count_done(25, n);
        check("busy_repulse/no_second_done", 32'(n), 32'd0);

        // Reset mid-operation aborts without a done pulse
        issue(OP_MUL, 16'd3, 16'd4, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/done", 32'(done), 32'd0);
        check("midrst/hi", 32'(hi), 32'd0);
        check("midrst/lo", 32'(lo), 32'd0);
        check("midrst/div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(25, n);
        check("midrst/no_done", 32'(n), 32'd0);
        check("sb/drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
